// File: rtl/morse_decoder_pkg.sv
// == morse_decoder_pkg : shared FSM states, element values and letter pattern table (rev 1.0) ==
`default_nettype none

package morse_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MARK  = 2'd1,
    ST_SPACE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic c_DOT  = 1'b0;
  localparam logic c_DASH = 1'b1;

  localparam int c_NUM_LETTERS = 8;
  localparam int c_MAX_ELEMS   = 4;

  // Table index is the letter code (A=0 .. H=7); patterns are right-aligned, first element sent in the MSB.
  localparam logic [2:0] c_PAT_LEN [c_NUM_LETTERS] = '{3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4};
  localparam logic [3:0] c_PAT_SYM [c_NUM_LETTERS] = '{4'b0001, 4'b1000, 4'b1010, 4'b0100,
                                                       4'b0000, 4'b0010, 4'b0110, 4'b0000};

endpackage

`default_nettype wire

// File: rtl/morse_pattern_lut.sv
// == morse_pattern_lut : (element count, dot/dash bits) -> letter code and hit flag (rev 1.0) ==
`default_nettype none

module morse_pattern_lut
  import morse_decoder_pkg::*;
(
  input  logic [2:0] i_n,
  input  logic [3:0] i_sym,
  output logic [2:0] o_code,
  output logic       o_hit
);

  always_comb begin
    o_code = 3'd0;
    o_hit  = 1'b0;
    for (int i = 0; i < c_NUM_LETTERS; i++) begin
      if ((i_n == c_PAT_LEN[i]) && (i_sym == c_PAT_SYM[i])) begin
        o_code = 3'(i);
        o_hit  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/morse_decoder.sv
// == morse_decoder : recovers A..H letter codes from a serial Morse lamp line (rev 1.0) ==
`default_nettype none

module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       sig_in,
  output logic [2:0] letter,
  output logic       letter_valid,
  output logic       err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_DOT_MAX  = CNT_W'(2 * TICK_DIV);
  localparam logic [CNT_W-1:0] c_MARK_LIM = CNT_W'(4 * TICK_DIV + 1);
  localparam logic [CNT_W-1:0] c_GAP_END  = CNT_W'(2 * TICK_DIV);

  if ((2 ** CNT_W) - 1 <= 4 * TICK_DIV) begin : g_cnt_w_too_small
    $error("morse_decoder: CNT_W too narrow to hold a too-long mark");
  end

  state_t           r_state, w_state_nxt;
  logic             r_sig_r;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]       r_sym, w_sym_nxt;
  logic [2:0]       r_n, w_n_nxt;
  logic [2:0]       r_letter, w_letter_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_err, w_err_nxt;
  logic             w_rise, w_fall, w_elem, w_hit;
  logic [2:0]       w_code;

  assign w_rise    = sig_in & ~r_sig_r;
  assign w_fall    = ~sig_in & r_sig_r;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + c_ONE;
  assign w_elem    = (r_cnt <= c_DOT_MAX) ? c_DOT : c_DASH;

  morse_pattern_lut u_lut (
    .i_n    (r_n),
    .i_sym  (r_sym),
    .o_code (w_code),
    .o_hit  (w_hit)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sym_nxt    = r_sym;
    w_n_nxt      = r_n;
    w_letter_nxt = r_letter;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_MARK;
          w_cnt_nxt   = c_ONE;
        end
      end
      ST_MARK: begin
        if (sig_in) begin
          if (w_cnt_inc == c_MARK_LIM) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (w_fall) begin
          // The falling sample is itself the first low clock of the following gap.
          w_cnt_nxt = c_ONE;
          if (r_n == 3'(c_MAX_ELEMS)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_sym_nxt   = {r_sym[2:0], w_elem};
            w_n_nxt     = r_n + 3'd1;
            w_state_nxt = ST_SPACE;
          end
        end
      end
      ST_SPACE: begin
        if (w_rise) begin
          w_state_nxt = ST_MARK;
          w_cnt_nxt   = c_ONE;
        end else if (r_cnt == c_GAP_END) begin
          w_letter_nxt = w_hit ? w_code : r_letter;
          w_valid_nxt  = w_hit;
          w_err_nxt    = ~w_hit;
          w_state_nxt  = ST_IDLE;
          w_sym_nxt    = '0;
          w_n_nxt      = '0;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_DRAIN: begin
        if (sig_in) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_GAP_END) begin
          w_state_nxt = ST_IDLE;
          w_sym_nxt   = '0;
          w_n_nxt     = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_state  <= ST_IDLE;
      r_sig_r  <= 1'b0;
      r_cnt    <= '0;
      r_sym    <= '0;
      r_n      <= '0;
      r_letter <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sig_r  <= sig_in;
      r_cnt    <= w_cnt_nxt;
      r_sym    <= w_sym_nxt;
      r_n      <= w_n_nxt;
      r_letter <= w_letter_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign letter       = r_letter;
  assign letter_valid = r_valid;
  assign err          = r_err;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire
